ifetch_ctrl: RTL and testbench

Front-end controller upstream of the fetch stage register in the 64-bit in-order pipeline. Owns the architectural fetch PC and drives the instruction bus. Holds each ibus request until `data_ok` and queues returned instructions in a 2-entry buffer toward fetch/decode. Handles taken-branch redirects, including redirects that arrive while a request is outstanding: the stale response is drained and discarded.

---
 rtl/ifetch_ctrl_if.sv | 25 ++
 rtl/ifetch_ctrl.sv | 134 +++++++++++++
 tb/tb_ifetch_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_ctrl_if.sv
// Instruction-bus request/response types and the bundle that carries them
// between the fetch controller (master) and the instruction memory (slave).
typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

typedef struct packed {
  logic        valid;
  logic [63:0] addr;
  msize_t      size;
  logic [7:0]  strobe;
  logic [63:0] data;
} ibus_req_t;

typedef struct packed {
  logic        addr_ok;
  logic        data_ok;
  logic [63:0] data;
} ibus_resp_t;

interface ifetch_ctrl_if;
  ibus_req_t  ireq;
  ibus_resp_t iresp;

  modport master (output ireq, input iresp);
  modport slave  (input ireq, output iresp);
endinterface

// File: rtl/ifetch_ctrl.sv
// Fetch front-end: owns the fetch PC, issues one ibus request at a time and
// buffers returned instructions in a 2-entry in-order queue.
//
// state | meaning
// IDLE  | no request on the bus; waiting for queue space
// REQ   | request to pc held on the bus until data_ok
// DRAIN | redirected while a request was in flight; stale response discarded
module ifetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic                clk,
  input  logic                reset,
  ifetch_ctrl_if.master       ibus,
  input  logic                redirect,
  input  logic [63:0]         redirect_pc,
  input  logic                stall,
  output logic                out_valid,
  output logic [63:0]         out_pc,
  output logic [31:0]         out_instr
);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t      state;
  logic        req_valid;
  logic [63:0] pc;
  logic [63:0] tgt;
  logic [63:0] q0_pc, q1_pc;
  logic [31:0] q0_instr, q1_instr;
  logic [1:0]  count;

  logic        data_ok;
  logic [31:0] rdata;
  logic [63:0] redir_pc;
  logic        pop;
  logic        push;
  logic [1:0]  cnt_pop;
  logic [1:0]  cnt_next;
  logic        unused_resp;

  assign data_ok     = ibus.iresp.data_ok;
  assign rdata       = ibus.iresp.data[31:0];
  assign unused_resp = ^{ibus.iresp.addr_ok, ibus.iresp.data[63:32]};
  assign redir_pc    = {redirect_pc[63:2], 2'b00};

  assign out_valid = (count != 2'd0);
  assign out_pc    = q0_pc;
  assign out_instr = q0_instr;

  assign pop      = out_valid & ~stall;
  assign push     = (state == REQ) & data_ok & ~redirect;
  assign cnt_pop  = count - {1'b0, pop};
  assign cnt_next = cnt_pop + {1'b0, push};

  assign ibus.ireq = '{valid: req_valid, addr: pc, size: MSIZE4,
                       strobe: 8'h00, data: 64'h0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_valid <= 1'b0;
      pc        <= RESET_PC;
      tgt       <= 64'h0;
      count     <= 2'd0;
      q0_pc     <= 64'h0;
      q0_instr  <= 32'h0;
      q1_pc     <= 64'h0;
      q1_instr  <= 32'h0;
    end else begin
      if (redirect) begin
        count <= 2'd0;
      end else begin
        count <= cnt_next;
        if (pop) begin
          q0_pc    <= q1_pc;
          q0_instr <= q1_instr;
        end
        // The new entry lands behind whatever survives this cycle's pop.
        if (push) begin
          if (cnt_pop == 2'd0) begin
            q0_pc    <= pc;
            q0_instr <= rdata;
          end else begin
            q1_pc    <= pc;
            q1_instr <= rdata;
          end
        end
      end

      case (state)
        IDLE: begin
          if (redirect) begin
            pc        <= redir_pc;
            state     <= REQ;
            req_valid <= 1'b1;
          end else if (cnt_pop <= 2'd1) begin
            state     <= REQ;
            req_valid <= 1'b1;
          end
        end
        REQ: begin
          if (redirect) begin
            if (data_ok) begin
              pc <= redir_pc;
            end else begin
              // Address must stay put until the bus answers.
              tgt   <= redir_pc;
              state <= DRAIN;
            end
          end else if (data_ok) begin
            pc <= pc + 64'd4;
            if (cnt_next >= 2'd2) begin
              state     <= IDLE;
              req_valid <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (data_ok) begin
            pc    <= redirect ? redir_pc : tgt;
            state <= REQ;
          end else if (redirect) begin
            tgt <= redir_pc;
          end
        end
        default: begin
          state     <= IDLE;
          req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: a flag-and-queue reference model checked every cycle,
// plus directed literal checks at key points of each scenario.
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        stall = 1'b0;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;

  ifetch_ctrl_if ibus();

  ifetch_ctrl #(.RESET_PC(64'h8000_0000)) dut (
    .clk(clk), .reset(reset), .ibus(ibus), .redirect(redirect),
    .redirect_pc(redirect_pc), .stall(stall), .out_valid(out_valid),
    .out_pc(out_pc), .out_instr(out_instr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: auto mode answers after mem_lat extra cycles; man_ok forces data_ok.
  logic        mem_auto = 1'b1;
  int unsigned mem_lat = 0;
  logic        man_ok = 1'b0;
  logic        mem_const = 1'b1;
  int unsigned wait_cnt;
  logic        data_ok_c;

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ 32'hA5A5_0000;
  endfunction

  always_comb begin
    data_ok_c = man_ok | (mem_auto & ibus.ireq.valid & (wait_cnt >= mem_lat));
    ibus.iresp = '0;
    ibus.iresp.addr_ok = ibus.ireq.valid;
    ibus.iresp.data_ok = data_ok_c;
    ibus.iresp.data = {32'hDEAD_BEEF, mem_const ? 32'h0000_0013 : word_of(ibus.ireq.addr)};
  end

  always @(posedge clk or posedge reset) begin
    if (reset) wait_cnt <= 0;
    else if (ibus.ireq.valid && !data_ok_c) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  // Reference model: a bus is either free or carrying one request; a request
  // overtaken by a redirect is marked stale and its answer thrown away.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        m_q[$];
  logic        m_busy, m_stale;
  logic [63:0] m_pc, m_tgt;

  always @(negedge clk) begin
    logic        pop, resp;
    logic [63:0] rpc;
    if (reset) begin
      chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
      chk("rst_out_pc", out_pc, 64'h0);
      chk("rst_out_instr", {32'h0, out_instr}, 64'h0);
      chk("rst_ireq_valid", {63'h0, ibus.ireq.valid}, 64'h0);
      m_q.delete();
      m_busy = 1'b0;
      m_stale = 1'b0;
      m_pc = 64'h8000_0000;
      m_tgt = 64'h0;
    end else begin
      chk("out_valid", {63'h0, out_valid}, {63'h0, m_q.size() != 0});
      if (m_q.size() != 0) begin
        chk("out_pc", out_pc, m_q[0].pc);
        chk("out_instr", {32'h0, out_instr}, {32'h0, m_q[0].instr});
      end
      chk("ireq_valid", {63'h0, ibus.ireq.valid}, {63'h0, m_busy});
      if (m_busy) begin
        chk("ireq_addr", ibus.ireq.addr, m_pc);
        chk("ireq_size", {62'h0, ibus.ireq.size}, 64'd2);
      end

      pop  = (m_q.size() != 0) && !stall;
      resp = m_busy && ibus.iresp.data_ok;
      rpc  = {redirect_pc[63:2], 2'b00};
      if (pop) void'(m_q.pop_front());
      if (resp) begin
        if (!m_stale && !redirect) m_q.push_back('{m_pc, ibus.iresp.data[31:0]});
        m_pc = redirect ? rpc : (m_stale ? m_tgt : m_pc + 64'd4);
        m_busy = redirect || m_stale || (m_q.size() <= 1);
        m_stale = 1'b0;
      end else if (m_busy) begin
        if (redirect) begin
          m_stale = 1'b1;
          m_tgt = rpc;
        end
      end else begin
        if (redirect) begin
          m_pc = rpc;
          m_busy = 1'b1;
        end else begin
          m_busy = (m_q.size() <= 1);
        end
      end
      if (redirect) m_q.delete();
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tick(2);
    reset = 1'b0;

    // Single-cycle memory returning 0x13 right after reset.
    tick(1);
    chk("t1_addr0", ibus.ireq.addr, 64'h8000_0000);
    chk("t1_valid0", {63'h0, ibus.ireq.valid}, 64'h1);
    tick(1);
    chk("t1_addr1", ibus.ireq.addr, 64'h8000_0004);
    chk("t1_outpc0", out_pc, 64'h8000_0000);
    chk("t1_instr0", {32'h0, out_instr}, 64'h13);
    tick(1);
    chk("t1_addr2", ibus.ireq.addr, 64'h8000_0008);
    chk("t1_outpc1", out_pc, 64'h8000_0004);

    // Stall held long enough to fill the queue.
    stall = 1'b1;
    tick(3);
    chk("t2_valid_low", {63'h0, ibus.ireq.valid}, 64'h0);
    chk("t2_outpc_frozen", out_pc, 64'h8000_0004);
    tick(2);
    chk("t2_outpc_still", out_pc, 64'h8000_0004);
    stall = 1'b0;
    tick(1);
    chk("t2_outpc_next", out_pc, 64'h8000_0008);
    chk("t2_addr_resume", ibus.ireq.addr, 64'h8000_000C);
    tick(4);

    // Three-cycle memory latency.
    mem_const = 1'b0;
    mem_lat = 2;
    tick(14);

    // Asynchronous reset in the middle of a transaction.
    chk("t4_valid_pre", {63'h0, ibus.ireq.valid}, 64'h1);
    reset = 1'b1;
    #1;
    chk("t4_valid", {63'h0, ibus.ireq.valid}, 64'h0);
    chk("t4_out_valid", {63'h0, out_valid}, 64'h0);
    chk("t4_out_pc", out_pc, 64'h0);
    tick(2);
    mem_auto = 1'b0;
    man_ok = 1'b0;
    reset = 1'b0;

    // Redirect while a request to 0x80000010 is outstanding.
    tick(1);
    man_ok = 1'b1;
    tick(4);
    man_ok = 1'b0;
    chk("t5_addr_pend", ibus.ireq.addr, 64'h8000_0010);
    redirect = 1'b1;
    redirect_pc = 64'h8000_1002;
    tick(1);
    redirect = 1'b0;
    chk("t5_flush", {63'h0, out_valid}, 64'h0);
    chk("t5_addr_hold", ibus.ireq.addr, 64'h8000_0010);
    tick(1);
    chk("t5_addr_hold2", ibus.ireq.addr, 64'h8000_0010);
    man_ok = 1'b1;
    tick(1);
    man_ok = 1'b0;
    chk("t5_addr_tgt", ibus.ireq.addr, 64'h8000_1000);
    chk("t5_stale_dropped", {63'h0, out_valid}, 64'h0);
    man_ok = 1'b1;
    tick(1);
    man_ok = 1'b0;
    chk("t5_first_tgt_out", out_pc, 64'h8000_1000);

    // Two redirects while draining: the newest target wins.
    redirect = 1'b1;
    redirect_pc = 64'h8000_2000;
    tick(1);
    redirect_pc = 64'h8000_3000;
    tick(1);
    redirect = 1'b0;
    tick(1);
    chk("t6_addr_hold", ibus.ireq.addr, 64'h8000_1004);
    man_ok = 1'b1;
    tick(1);
    man_ok = 1'b0;
    chk("t6_addr_newest", ibus.ireq.addr, 64'h8000_3000);
    chk("t6_empty", {63'h0, out_valid}, 64'h0);

    // Redirect, stall and data_ok together.
    man_ok = 1'b1;
    tick(1);
    chk("t7_head", out_pc, 64'h8000_3000);
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 64'h8000_4000;
    tick(1);
    stall = 1'b0;
    chk("t7_flush", {63'h0, out_valid}, 64'h0);
    chk("t7_addr", ibus.ireq.addr, 64'h8000_4000);

    // Redirect to the top of the address space, then wrap.
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    tick(1);
    redirect = 1'b0;
    chk("t8_addr_top", ibus.ireq.addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick(1);
    man_ok = 1'b0;
    chk("t8_addr_wrap", ibus.ireq.addr, 64'h0);
    chk("t8_out_top", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    // Redirect from a full, stalled queue.
    mem_auto = 1'b1;
    mem_lat = 0;
    stall = 1'b1;
    tick(3);
    chk("t9_idle", {63'h0, ibus.ireq.valid}, 64'h0);
    redirect = 1'b1;
    redirect_pc = 64'h8000_5000;
    tick(1);
    redirect = 1'b0;
    stall = 1'b0;
    chk("t9_flush", {63'h0, out_valid}, 64'h0);
    chk("t9_addr", ibus.ireq.addr, 64'h8000_5000);
    tick(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
